// File: rtl/pcie_pkg.sv
// pcie_pkg: shared TLP channel widths and arbiter state type.
// No ports. Widths come from the `TLP_* defines; the channel is single-segment.
`ifndef TLP_DATA_WIDTH
`define TLP_DATA_WIDTH 64
`endif
`ifndef TLP_HDR_WIDTH
`define TLP_HDR_WIDTH 128
`endif

package pcie_pkg;

    localparam int TLP_DATA_WIDTH = `TLP_DATA_WIDTH;
    localparam int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 32;
    localparam int TLP_HDR_WIDTH  = `TLP_HDR_WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } cpl_arb_state_e;

endpackage

// File: rtl/pcie_cpl_tlp_arb_if.sv
// pcie_cpl_tlp_arb_if: N-lane TLP stream bundle (data/strb/hdr/valid/sop/eop/ready).
// Lane i occupies slice i of each vector; master drives beats, slave drives ready.
interface pcie_cpl_tlp_arb_if
    import pcie_pkg::*;
#(
    parameter int N  = 1,
    parameter int DW = TLP_DATA_WIDTH,
    parameter int SW = TLP_STRB_WIDTH,
    parameter int HW = TLP_HDR_WIDTH
);

    logic [N*DW-1:0] data;
    logic [N*SW-1:0] strb;
    logic [N*HW-1:0] hdr;
    logic [N-1:0]    valid;
    logic [N-1:0]    sop;
    logic [N-1:0]    eop;
    logic [N-1:0]    ready;

    modport master (
        output data, strb, hdr, valid, sop, eop,
        input  ready
    );

    modport slave (
        input  data, strb, hdr, valid, sop, eop,
        output ready
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select, first request at or above ptr.
// Ports: req (per-port request), ptr (start index), gnt_idx, gnt_any.
module rr_pick #(
    parameter int PORTS = 2
) (
    input  logic [PORTS-1:0]         req,
    input  logic [$clog2(PORTS)-1:0] ptr,
    output logic [$clog2(PORTS)-1:0] gnt_idx,
    output logic                     gnt_any
);

    localparam int GW = $clog2(PORTS);

    logic          hit;
    logic [GW-1:0] idx;

    // Two upward passes: first the ports at or above ptr,
    // then wrap around to the lowest requester overall.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (!hit && req[k] && (GW'(k) >= ptr)) begin
                hit = 1'b1;
                idx = GW'(k);
            end
        end
        for (int k = 0; k < PORTS; k++) begin
            if (!hit && req[k]) begin
                hit = 1'b1;
                idx = GW'(k);
            end
        end
        gnt_any = hit;
        gnt_idx = idx;
    end

endmodule

// File: rtl/pcie_cpl_tlp_arb.sv
// pcie_cpl_tlp_arb: packet-granular round-robin arbiter onto the TX completion channel.
// Ports: clk, rst (async, active-low), s_tlp (PORTS sources, slave),
// tx_cpl_tlp (registered output, master), grant_id, busy, sop_err.
module pcie_cpl_tlp_arb
    import pcie_pkg::*;
#(
    parameter int PORTS      = 2,
    parameter int DATA_WIDTH = TLP_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 32,
    parameter int HDR_WIDTH  = TLP_HDR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    pcie_cpl_tlp_arb_if.slave        s_tlp,
    pcie_cpl_tlp_arb_if.master       tx_cpl_tlp,
    output logic [$clog2(PORTS)-1:0] grant_id,
    output logic                     busy,
    output logic                     sop_err
);

    localparam int GW = $clog2(PORTS);

    cpl_arb_state_e state_q, state_d;

    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         gnt_q, gnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
    logic                  vld_q, vld_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;

    logic [PORTS-1:0]      req;
    logic [PORTS-1:0]      bad;
    logic [PORTS-1:0]      rdy;
    logic [GW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  can_load;
    logic                  acc;

    logic                  sel_vld;
    logic                  sel_sop;
    logic                  sel_eop;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [STRB_WIDTH-1:0] sel_strb;
    logic [HDR_WIDTH-1:0]  sel_hdr;

    assign req = s_tlp.valid & s_tlp.sop;
    assign bad = s_tlp.valid & ~s_tlp.sop;

    rr_pick #(
        .PORTS (PORTS)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // Beat mux driven by the latched grant only.
    always_comb begin
        sel_vld  = 1'b0;
        sel_sop  = 1'b0;
        sel_eop  = 1'b0;
        sel_data = '0;
        sel_strb = '0;
        sel_hdr  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (gnt_q == GW'(i)) begin
                sel_vld  = s_tlp.valid[i];
                sel_sop  = s_tlp.sop[i];
                sel_eop  = s_tlp.eop[i];
                sel_data = s_tlp.data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_strb = s_tlp.strb[i*STRB_WIDTH +: STRB_WIDTH];
                sel_hdr  = s_tlp.hdr[i*HDR_WIDTH +: HDR_WIDTH];
            end
        end
    end

    // Ready depends only on state, grant and downstream ready,
    // never on the source valid.
    assign can_load = !vld_q || tx_cpl_tlp.ready[0];

    always_comb begin
        rdy = '0;
        for (int i = 0; i < PORTS; i++) begin
            rdy[i] = (state_q == PASS) && (gnt_q == GW'(i)) && can_load;
        end
    end

    assign acc = (state_q == PASS) && can_load && sel_vld;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        strb_d  = strb_q;
        hdr_d   = hdr_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        vld_d   = vld_q && !tx_cpl_tlp.ready[0];
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (acc) begin
                    vld_d  = 1'b1;
                    data_d = sel_data;
                    strb_d = sel_strb;
                    sop_d  = sel_sop;
                    eop_d  = sel_eop;
                    if (sel_sop) begin
                        hdr_d = sel_hdr;
                    end
                    if (sel_eop) begin
                        state_d = IDLE;
                        ptr_d   = (gnt_q == GW'(PORTS - 1)) ?
                                  '0 : gnt_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            hdr_q   <= '0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            hdr_q   <= hdr_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign s_tlp.ready      = rdy;
    assign tx_cpl_tlp.data  = data_q;
    assign tx_cpl_tlp.strb  = strb_q;
    assign tx_cpl_tlp.hdr   = hdr_q;
    assign tx_cpl_tlp.valid = vld_q;
    assign tx_cpl_tlp.sop   = sop_q;
    assign tx_cpl_tlp.eop   = eop_q;

    assign grant_id = gnt_q;
    assign busy     = (state_q == PASS);
    assign sop_err  = (state_q == IDLE) && (|bad);

endmodule

// File: tb/tb_pcie_cpl_tlp_arb.sv
// tb_pcie_cpl_tlp_arb: directed bench for the completion TLP arbiter.
// Drives two sources and a downstream ready; checks the registered output.
module tb_pcie_cpl_tlp_arb;

    import pcie_pkg::*;

    localparam int P  = 2;
    localparam int DW = 64;
    localparam int SW = 2;
    localparam int HW = 128;

    localparam logic [HW-1:0] HA5 = {4{32'hA5A5_A5A5}};
    localparam logic [HW-1:0] H0  = {4{32'h0000_1111}};
    localparam logic [HW-1:0] H1  = {4{32'h0000_2222}};
    localparam logic [HW-1:0] HB  = {4{32'hBBBB_0001}};
    localparam logic [HW-1:0] HC  = {4{32'hCCCC_0002}};
    localparam logic [HW-1:0] HD  = {4{32'hDDDD_0003}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic sop_err;
    logic [0:0] grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    pcie_cpl_tlp_arb_if #(.N(P), .DW(DW), .SW(SW), .HW(HW)) src ();
    pcie_cpl_tlp_arb_if #(.N(1), .DW(DW), .SW(SW), .HW(HW)) tx ();

    pcie_cpl_tlp_arb #(
        .PORTS      (P),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .HDR_WIDTH  (HW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tlp      (src),
        .tx_cpl_tlp (tx),
        .grant_id   (grant_id),
        .busy       (busy),
        .sop_err    (sop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: no summary after 200000 time units");
        $fatal(1);
    end

    function automatic logic [DW-1:0] dv(int p, int b);
        return {8'hD0, 40'h0, 8'(p), 8'(b)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic src_set(int p, logic v, logic s, logic e, logic [DW-1:0] d);
        src.valid[p] = v;
        src.sop[p]   = s;
        src.eop[p]   = e;
        src.data[p*DW +: DW] = d;
        src.strb[p*SW +: SW] = e ? 2'b01 : 2'b11;
    endtask

    task automatic hdr_set(int p, logic [HW-1:0] h);
        src.hdr[p*HW +: HW] = h;
    endtask

    // Output beat check; last beats carry strb 01, others 11.
    task automatic out(string tag, logic v, logic s, logic e, logic [DW-1:0] d);
        chk({tag, ".vld"}, 128'(tx.valid), 128'(v));
        if (v) begin
            chk({tag, ".sop"}, 128'(tx.sop), 128'(s));
            chk({tag, ".eop"}, 128'(tx.eop), 128'(e));
            chk({tag, ".data"}, 128'(tx.data), 128'(d));
            chk({tag, ".strb"}, 128'(tx.strb), e ? 128'd1 : 128'd3);
        end
    endtask

    task automatic st(string tag, logic [1:0] r, logic b, logic g);
        chk({tag, ".rdy"}, 128'(src.ready), 128'(r));
        chk({tag, ".busy"}, 128'(busy), 128'(b));
        chk({tag, ".gnt"}, 128'(grant_id), 128'(g));
    endtask

    initial begin
        src.valid = '0;
        src.sop   = '0;
        src.eop   = '0;
        src.data  = '0;
        src.strb  = '0;
        src.hdr   = '0;
        tx.ready  = 1'b1;

        // Reset values
        tick;
        tick;
        chk("rst.vld", 128'(tx.valid), 128'd0);
        chk("rst.sop", 128'(tx.sop), 128'd0);
        chk("rst.eop", 128'(tx.eop), 128'd0);
        chk("rst.data", 128'(tx.data), 128'd0);
        chk("rst.strb", 128'(tx.strb), 128'd0);
        chk("rst.hdr", 128'(tx.hdr), 128'd0);
        chk("rst.err", 128'(sop_err), 128'd0);
        st("rst", 2'b00, 1'b0, 1'b0);
        rst = 1'b1;

        // Protocol error: valid without sop in IDLE
        tick;
        src_set(0, 1, 0, 0, dv(0, 0));
        #1;
        chk("perr.err0", 128'(sop_err), 128'd1);
        st("perr0", 2'b00, 1'b0, 1'b0);
        tick;
        #1;
        chk("perr.err1", 128'(sop_err), 128'd1);
        out("perr1", 0, 0, 0, '0);
        st("perr1", 2'b00, 1'b0, 1'b0);
        tick;
        src_set(0, 0, 0, 0, '0);
        #1;
        chk("perr.err2", 128'(sop_err), 128'd0);
        out("perr2", 0, 0, 0, '0);

        // Contention: P0, P1, P0, P1 with 2-beat packets
        tick;
        src_set(0, 1, 1, 0, dv(0, 0));
        src_set(1, 1, 1, 0, dv(1, 0));
        hdr_set(0, H0);
        hdr_set(1, H1);
        #1;
        st("c0", 2'b00, 1'b0, 1'b0);
        tick;
        #1;
        out("c1", 0, 0, 0, '0);
        st("c1", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 0, 1, dv(0, 1));
        #1;
        out("c2", 1, 1, 0, dv(0, 0));
        chk("c2.hdr", 128'(tx.hdr), 128'(H0));
        st("c2", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 1, 0, dv(0, 2));
        #1;
        out("c3", 1, 0, 1, dv(0, 1));
        chk("c3.err", 128'(sop_err), 128'd0);
        st("c3", 2'b00, 1'b0, 1'b0);
        tick;
        #1;
        out("c4", 0, 0, 0, '0);
        st("c4", 2'b10, 1'b1, 1'b1);
        tick;
        src_set(1, 1, 0, 1, dv(1, 1));
        #1;
        out("c5", 1, 1, 0, dv(1, 0));
        chk("c5.hdr", 128'(tx.hdr), 128'(H1));
        st("c5", 2'b10, 1'b1, 1'b1);
        tick;
        src_set(1, 1, 1, 0, dv(1, 2));
        #1;
        out("c6", 1, 0, 1, dv(1, 1));
        st("c6", 2'b00, 1'b0, 1'b1);
        tick;
        #1;
        out("c7", 0, 0, 0, '0);
        st("c7", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 0, 1, dv(0, 3));
        #1;
        out("c8", 1, 1, 0, dv(0, 2));
        tick;
        src_set(0, 0, 0, 0, '0);
        #1;
        out("c9", 1, 0, 1, dv(0, 3));
        st("c9", 2'b00, 1'b0, 1'b0);
        tick;
        #1;
        out("c10", 0, 0, 0, '0);
        st("c10", 2'b10, 1'b1, 1'b1);
        tick;
        src_set(1, 1, 0, 1, dv(1, 3));
        #1;
        out("c11", 1, 1, 0, dv(1, 2));
        tick;
        src_set(1, 0, 0, 0, '0);
        #1;
        out("c12", 1, 0, 1, dv(1, 3));
        tick;
        #1;
        out("c13", 0, 0, 0, '0);
        st("c13", 2'b00, 1'b0, 1'b1);

        // Single source: 3-beat TLP on port 0
        tick;
        src_set(0, 1, 1, 0, dv(0, 4));
        hdr_set(0, HA5);
        #1;
        st("s0", 2'b00, 1'b0, 1'b1);
        tick;
        #1;
        out("s1", 0, 0, 0, '0);
        st("s1", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 0, 0, dv(0, 5));
        #1;
        out("s2", 1, 1, 0, dv(0, 4));
        chk("s2.hdr", 128'(tx.hdr), 128'(HA5));
        tick;
        src_set(0, 1, 0, 1, dv(0, 6));
        #1;
        out("s3", 1, 0, 0, dv(0, 5));
        tick;
        src_set(0, 0, 0, 0, '0);
        #1;
        out("s4", 1, 0, 1, dv(0, 6));
        st("s4", 2'b00, 1'b0, 1'b0);

        // Both request: rr_ptr is 1, so the port-1 single beat wins,
        // then port 0 sends 4 beats under ready 1,0,0,1.
        tick;
        src_set(0, 1, 1, 0, dv(0, 8));
        src_set(1, 1, 1, 1, dv(1, 8));
        hdr_set(1, HB);
        #1;
        out("b0", 0, 0, 0, '0);
        st("b0", 2'b00, 1'b0, 1'b0);
        tick;
        #1;
        st("b1", 2'b10, 1'b1, 1'b1);
        tick;
        src_set(1, 0, 0, 0, '0);
        #1;
        out("b2", 1, 1, 1, dv(1, 8));
        chk("b2.hdr", 128'(tx.hdr), 128'(HB));
        st("b2", 2'b00, 1'b0, 1'b1);
        tick;
        #1;
        out("b3", 0, 0, 0, '0);
        st("b3", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 0, 0, dv(0, 9));
        #1;
        out("b4", 1, 1, 0, dv(0, 8));
        st("b4", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 0, 0, dv(0, 10));
        tx.ready = 1'b0;
        #1;
        out("b5", 1, 0, 0, dv(0, 9));
        st("b5", 2'b00, 1'b1, 1'b0);
        tick;
        #1;
        out("b6", 1, 0, 0, dv(0, 9));
        st("b6", 2'b00, 1'b1, 1'b0);
        tick;
        tx.ready = 1'b1;
        #1;
        out("b7", 1, 0, 0, dv(0, 9));
        st("b7", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 0, 1, dv(0, 11));
        #1;
        out("b8", 1, 0, 0, dv(0, 10));
        st("b8", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 0, 0, 0, '0);
        tx.ready = 1'b0;
        #1;
        out("b9", 1, 0, 1, dv(0, 11));
        st("b9", 2'b00, 1'b0, 1'b0);
        tick;
        tx.ready = 1'b1;
        #1;
        out("b10", 1, 0, 1, dv(0, 11));
        tick;
        #1;
        out("b11", 0, 0, 0, '0);

        // Single-beat TLP on port 1 arrives while port 0 is mid-packet
        tick;
        src_set(0, 1, 1, 0, dv(0, 12));
        #1;
        st("m0", 2'b00, 1'b0, 1'b0);
        tick;
        #1;
        st("m1", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 0, 0, dv(0, 13));
        src_set(1, 1, 1, 1, dv(1, 12));
        hdr_set(1, HC);
        #1;
        out("m2", 1, 1, 0, dv(0, 12));
        st("m2", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 0, 1, dv(0, 14));
        #1;
        out("m3", 1, 0, 0, dv(0, 13));
        st("m3", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 0, 0, 0, '0);
        #1;
        out("m4", 1, 0, 1, dv(0, 14));
        st("m4", 2'b00, 1'b0, 1'b0);
        tick;
        #1;
        out("m5", 0, 0, 0, '0);
        st("m5", 2'b10, 1'b1, 1'b1);
        tick;
        src_set(1, 0, 0, 0, '0);
        #1;
        out("m6", 1, 1, 1, dv(1, 12));
        chk("m6.hdr", 128'(tx.hdr), 128'(HC));
        tick;
        #1;
        out("m7", 0, 0, 0, '0);

        // Async reset after beat 2 of a 4-beat packet
        tick;
        src_set(0, 1, 1, 0, dv(0, 16));
        #1;
        tick;
        #1;
        st("a1", 2'b01, 1'b1, 1'b0);
        tick;
        src_set(0, 1, 0, 0, dv(0, 17));
        #1;
        out("a2", 1, 1, 0, dv(0, 16));
        tick;
        src_set(0, 1, 0, 0, dv(0, 18));
        #1;
        out("a3", 1, 0, 0, dv(0, 17));
        #2;
        rst = 1'b0;
        #1;
        chk("ar.vld", 128'(tx.valid), 128'd0);
        chk("ar.data", 128'(tx.data), 128'd0);
        st("ar", 2'b00, 1'b0, 1'b0);
        src_set(0, 0, 0, 0, '0);
        tick;
        tick;
        rst = 1'b1;
        tick;
        src_set(1, 1, 1, 0, dv(1, 20));
        hdr_set(1, HD);
        #1;
        st("a4", 2'b00, 1'b0, 1'b0);
        tick;
        #1;
        out("a5", 0, 0, 0, '0);
        st("a5", 2'b10, 1'b1, 1'b1);
        tick;
        src_set(1, 1, 0, 1, dv(1, 21));
        #1;
        out("a6", 1, 1, 0, dv(1, 20));
        chk("a6.hdr", 128'(tx.hdr), 128'(HD));
        tick;
        src_set(1, 0, 0, 0, '0);
        #1;
        out("a7", 1, 0, 1, dv(1, 21));
        tick;
        #1;
        out("a8", 0, 0, 0, '0);
        st("a8", 2'b00, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
